// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: memory FSM states and the bundled load/flush control word
package pipe_hazard_ctrl_pkg;
  typedef enum logic [1:0] {M_IDLE, M_ACC, M_IND1, M_IND2} lc3b_mem_state;
  typedef struct packed {
    logic load_pc;
    logic load_if_id;
    logic load_id_ex;
    logic load_ex_mem;
    logic load_mem_wb;
    logic flush_if_id;
    logic flush_id_ex;
    logic flush_ex_mem;
  } lc3b_pipe_ctrl;
  localparam lc3b_pipe_ctrl CTRL_HOLD = 8'b00000_000;
  localparam lc3b_pipe_ctrl CTRL_RUN = 8'b11111_000;
  localparam lc3b_pipe_ctrl CTRL_LU = 8'b00111_010;
  localparam lc3b_pipe_ctrl CTRL_BR = 8'b11111_111;
endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// hazard_detect: load-use compare between the ID/EX load and the IF/ID sources
module hazard_detect (
  input  logic       idex_mem_read,
  input  logic [2:0] idex_dest,
  input  logic [2:0] ifid_src1,
  input  logic [2:0] ifid_src2,
  input  logic       ifid_src2_used,
  output logic       lu
);
  assign lu = idex_mem_read & ((idex_dest == ifid_src1) | (ifid_src2_used & (idex_dest == ifid_src2)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer with memory handshakes; PERF_CNT_EN adds stall counters
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
`ifdef PERF_CNT_EN
  #(parameter int CNT_W = 16)
`endif
  (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       imem_resp,
  output logic       imem_read,
  input  logic       mem_read_req,
  input  logic       mem_write_req,
  input  logic       mem_indirect,
  input  logic       dmem_resp,
  output logic       dmem_read,
  output logic       dmem_write,
  output logic       ind_phase2,
  output logic       mdr_load,
  input  logic       idex_mem_read,
  input  logic [2:0] idex_dest,
  input  logic [2:0] ifid_src1,
  input  logic [2:0] ifid_src2,
  input  logic       ifid_src2_used,
  input  logic       br_taken,
  output logic       load_pc,
  output logic       load_if_id,
  output logic       load_id_ex,
  output logic       load_ex_mem,
  output logic       load_mem_wb,
  output logic       flush_if_id,
  output logic       flush_id_ex,
  output logic       flush_ex_mem
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_if_cnt,
  output logic [CNT_W-1:0] stall_mem_cnt,
  output logic [CNT_W-1:0] stall_lu_cnt
`endif
);
  lc3b_mem_state st, nxt;
  lc3b_pipe_ctrl ctl;
  logic fetch_done, mem_held, lu, op, done, mem_busy, if_busy, stall;
  hazard_detect u_hd (
    .idex_mem_read (idex_mem_read),
    .idex_dest     (idex_dest),
    .ifid_src1     (ifid_src1),
    .ifid_src2     (ifid_src2),
    .ifid_src2_used(ifid_src2_used),
    .lu            (lu)
  );
  // mem_held marks an op already completed while the pipeline stayed frozen, so it is not reissued
  assign op = (mem_read_req | mem_write_req) & !mem_held;
  assign mem_busy = op & !done;
  assign if_busy = !(imem_resp | fetch_done);
  assign stall = mem_busy | if_busy;
  assign ctl = (!rst_n || stall) ? CTRL_HOLD : br_taken ? CTRL_BR : lu ? CTRL_LU : CTRL_RUN;
  assign imem_read = rst_n & !fetch_done;
  assign {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex, flush_ex_mem} = ctl;
  // memory FSM next state and data-memory strobes
  always_comb begin
    nxt = st;
    dmem_read = 1'b0;
    dmem_write = 1'b0;
    ind_phase2 = 1'b0;
    mdr_load = 1'b0;
    done = 1'b0;
    case (st)
      M_IDLE: nxt = op ? (mem_indirect ? M_IND1 : M_ACC) : M_IDLE;
      M_ACC: begin
        dmem_read = mem_read_req;
        dmem_write = mem_write_req;
        mdr_load = dmem_resp & mem_read_req;
        done = dmem_resp;
        nxt = dmem_resp ? M_IDLE : M_ACC;
      end
      M_IND1: begin
        dmem_read = 1'b1;
        mdr_load = dmem_resp;
        nxt = dmem_resp ? M_IND2 : M_IND1;
      end
      default: begin
        ind_phase2 = 1'b1;
        dmem_read = mem_read_req;
        dmem_write = mem_write_req;
        mdr_load = dmem_resp & mem_read_req;
        done = dmem_resp;
        nxt = dmem_resp ? M_IDLE : M_IND2;
      end
    endcase
  end
  // FSM state, fetched-word hold and completed-op hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= M_IDLE;
      fetch_done <= 1'b0;
      mem_held <= 1'b0;
    end else begin
      st <= nxt;
      fetch_done <= stall & (fetch_done | imem_resp);
      mem_held <= !ctl.load_ex_mem & (mem_held | done);
    end
  end
`ifdef PERF_CNT_EN
  // saturating stall counters, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_if_cnt <= '0;
      stall_mem_cnt <= '0;
      stall_lu_cnt <= '0;
    end else begin
      stall_if_cnt <= stall_if_cnt + CNT_W'(if_busy & !mem_busy & ~&stall_if_cnt);
      stall_mem_cnt <= stall_mem_cnt + CNT_W'(mem_busy & ~&stall_mem_cnt);
      stall_lu_cnt <= stall_lu_cnt + CNT_W'(!stall & lu & !br_taken & ~&stall_lu_cnt);
    end
  end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed self-checking bench for pipe_hazard_ctrl (counters checked when PERF_CNT_EN is defined)
module tb_pipe_hazard_ctrl;
  logic clk = 0, rst_n = 1, imem_resp = 0, mem_read_req = 0, mem_write_req = 0, mem_indirect = 0, dmem_resp = 0;
  logic idex_mem_read = 0, ifid_src2_used = 0, br_taken = 0;
  logic [2:0] idex_dest = 0, ifid_src1 = 0, ifid_src2 = 0;
  logic imem_read, dmem_read, dmem_write, ind_phase2, mdr_load;
  logic load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex, flush_ex_mem;
  logic [7:0] ctl;
  int errors = 0, checks = 0;
  localparam logic [7:0] HOLD = 8'b00000_000, RUN = 8'b11111_000, LUB = 8'b00111_010, BRF = 8'b11111_111;
`ifdef PERF_CNT_EN
  logic [15:0] stall_if_cnt, stall_mem_cnt, stall_lu_cnt;
`endif
  pipe_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .imem_resp(imem_resp), .imem_read(imem_read),
    .mem_read_req(mem_read_req), .mem_write_req(mem_write_req), .mem_indirect(mem_indirect),
    .dmem_resp(dmem_resp), .dmem_read(dmem_read), .dmem_write(dmem_write), .ind_phase2(ind_phase2),
    .mdr_load(mdr_load), .idex_mem_read(idex_mem_read), .idex_dest(idex_dest), .ifid_src1(ifid_src1),
    .ifid_src2(ifid_src2), .ifid_src2_used(ifid_src2_used), .br_taken(br_taken),
    .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex), .load_ex_mem(load_ex_mem),
    .load_mem_wb(load_mem_wb), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem)
`ifdef PERF_CNT_EN
    , .stall_if_cnt(stall_if_cnt), .stall_mem_cnt(stall_mem_cnt), .stall_lu_cnt(stall_lu_cnt)
`endif
  );
  assign ctl = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex, flush_ex_mem};
  always #5 clk = ~clk;
  task cyc;
    @(posedge clk);
    #1;
  endtask
  task idle_in;
    imem_resp = 0; mem_read_req = 0; mem_write_req = 0; mem_indirect = 0; dmem_resp = 0;
    idex_mem_read = 0; ifid_src2_used = 0; br_taken = 0; idex_dest = 0; ifid_src1 = 0; ifid_src2 = 0;
  endtask
  task test_reset;
    rst_n = 0; imem_resp = 1; mem_read_req = 1; dmem_resp = 1;
    #1;
    checks++; if (imem_read !== 1'b0) begin errors++; $display("FAIL rst_imem_read got=%b exp=0", imem_read); end
    checks++; if (ctl !== HOLD) begin errors++; $display("FAIL rst_ctl got=%b exp=%b", ctl, HOLD); end
    cyc; cyc;
    checks++; if ({dmem_read, dmem_write, mdr_load, ind_phase2} !== 4'b0) begin errors++; $display("FAIL rst_mem got=%b exp=0000", {dmem_read, dmem_write, mdr_load, ind_phase2}); end
`ifdef PERF_CNT_EN
    checks++; if ({stall_if_cnt, stall_mem_cnt, stall_lu_cnt} !== 48'd0) begin errors++; $display("FAIL rst_cnt got=%0d/%0d/%0d exp=0/0/0", stall_if_cnt, stall_mem_cnt, stall_lu_cnt); end
`endif
    idle_in;
    rst_n = 1;
    #1;
    checks++; if (imem_read !== 1'b1) begin errors++; $display("FAIL rel_imem_read got=%b exp=1", imem_read); end
    checks++; if (ctl !== HOLD) begin errors++; $display("FAIL rel_ctl got=%b exp=%b", ctl, HOLD); end
  endtask
  task test_fetch;
    for (int i = 0; i < 3; i++) begin
      imem_resp = 0; #1;
      checks++; if (imem_read !== 1'b1) begin errors++; $display("FAIL fetch_wait%0d imem_read got=%b exp=1", i, imem_read); end
      checks++; if (ctl !== HOLD) begin errors++; $display("FAIL fetch_wait%0d ctl got=%b exp=%b", i, ctl, HOLD); end
      cyc;
      imem_resp = 1; #1;
      checks++; if (ctl !== RUN) begin errors++; $display("FAIL fetch_resp%0d ctl got=%b exp=%b", i, ctl, RUN); end
      cyc;
    end
  endtask
  task test_ldr;
    idle_in; mem_read_req = 1; imem_resp = 1; #1;
    checks++; if ({ctl, dmem_read} !== {HOLD, 1'b0}) begin errors++; $display("FAIL ldr_c0 got=%b exp=%b", {ctl, dmem_read}, {HOLD, 1'b0}); end
    cyc;
    for (int i = 1; i < 3; i++) begin
      imem_resp = 0; #1;
      checks++; if ({ctl, dmem_read, mdr_load, imem_read} !== {HOLD, 3'b100}) begin errors++; $display("FAIL ldr_c%0d got=%b exp=%b", i, {ctl, dmem_read, mdr_load, imem_read}, {HOLD, 3'b100}); end
      cyc;
    end
    dmem_resp = 1; #1;
    checks++; if ({ctl, dmem_read, mdr_load} !== {RUN, 2'b11}) begin errors++; $display("FAIL ldr_c3 got=%b exp=%b", {ctl, dmem_read, mdr_load}, {RUN, 2'b11}); end
    cyc;
    idle_in; imem_resp = 1; #1;
    checks++; if ({ctl, dmem_read, mdr_load} !== {RUN, 2'b00}) begin errors++; $display("FAIL ldr_c4 got=%b exp=%b", {ctl, dmem_read, mdr_load}, {RUN, 2'b00}); end
    cyc;
  endtask
  task test_back_to_back;
    idle_in; mem_write_req = 1; #1;
    checks++; if ({ctl, dmem_write} !== {HOLD, 1'b0}) begin errors++; $display("FAIL b2b_c0 got=%b exp=%b", {ctl, dmem_write}, {HOLD, 1'b0}); end
    cyc;
    dmem_resp = 1; #1;
    checks++; if ({ctl, dmem_write, mdr_load} !== {HOLD, 2'b10}) begin errors++; $display("FAIL b2b_c1 got=%b exp=%b", {ctl, dmem_write, mdr_load}, {HOLD, 2'b10}); end
    cyc;
    dmem_resp = 0; #1;
    checks++; if ({ctl, dmem_write} !== {HOLD, 1'b0}) begin errors++; $display("FAIL b2b_noreissue got=%b exp=%b", {ctl, dmem_write}, {HOLD, 1'b0}); end
    cyc;
    imem_resp = 1; #1;
    checks++; if ({ctl, dmem_write} !== {RUN, 1'b0}) begin errors++; $display("FAIL b2b_c3 got=%b exp=%b", {ctl, dmem_write}, {RUN, 1'b0}); end
    cyc;
    mem_write_req = 0; #1;
    checks++; if (ctl !== RUN) begin errors++; $display("FAIL b2b_c4 got=%b exp=%b", ctl, RUN); end
    cyc;
  endtask
  task test_ldi;
    logic [3:0] exp_m [5];
    logic [7:0] exp_c [5];
    logic resp_seq [5];
    exp_m = '{4'b0000, 4'b1000, 4'b1100, 4'b1010, 4'b1110};
    exp_c = '{HOLD, HOLD, HOLD, HOLD, RUN};
    resp_seq = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    idle_in; mem_read_req = 1; mem_indirect = 1;
    for (int i = 0; i < 5; i++) begin
      dmem_resp = resp_seq[i]; imem_resp = (i == 4); #1;
      checks++; if ({ctl, dmem_read, mdr_load, ind_phase2, dmem_write} !== {exp_c[i], exp_m[i]}) begin errors++; $display("FAIL ldi_c%0d got=%b exp=%b", i, {ctl, dmem_read, mdr_load, ind_phase2, dmem_write}, {exp_c[i], exp_m[i]}); end
      cyc;
    end
    idle_in; imem_resp = 1; #1;
    checks++; if ({ctl, dmem_read, ind_phase2} !== {RUN, 2'b00}) begin errors++; $display("FAIL ldi_c5 got=%b exp=%b", {ctl, dmem_read, ind_phase2}, {RUN, 2'b00}); end
    cyc;
  endtask
  task test_load_use;
    idle_in; imem_resp = 1; idex_mem_read = 1; idex_dest = 3; ifid_src1 = 3; ifid_src2 = 5; ifid_src2_used = 1; #1;
    checks++; if (ctl !== LUB) begin errors++; $display("FAIL lu_src1 got=%b exp=%b", ctl, LUB); end
    cyc;
    idex_mem_read = 0; #1;
    checks++; if (ctl !== RUN) begin errors++; $display("FAIL lu_after got=%b exp=%b", ctl, RUN); end
    cyc;
    idex_mem_read = 1; idex_dest = 4; ifid_src1 = 1; ifid_src2 = 4; ifid_src2_used = 0; #1;
    checks++; if (ctl !== RUN) begin errors++; $display("FAIL lu_src2_unused got=%b exp=%b", ctl, RUN); end
    cyc;
    ifid_src2_used = 1; #1;
    checks++; if (ctl !== LUB) begin errors++; $display("FAIL lu_src2_used got=%b exp=%b", ctl, LUB); end
    cyc;
    idex_mem_read = 0; #1;
    checks++; if (ctl !== RUN) begin errors++; $display("FAIL lu_after2 got=%b exp=%b", ctl, RUN); end
    cyc;
    idex_mem_read = 1; imem_resp = 0; #1;
    checks++; if (ctl !== HOLD) begin errors++; $display("FAIL lu_in_stall got=%b exp=%b", ctl, HOLD); end
    cyc;
    idex_mem_read = 0; imem_resp = 1; #1;
    checks++; if (ctl !== RUN) begin errors++; $display("FAIL lu_resume got=%b exp=%b", ctl, RUN); end
    cyc;
  endtask
  task test_branch;
    idle_in; imem_resp = 1; br_taken = 1; idex_mem_read = 1; idex_dest = 2; ifid_src1 = 2; #1;
    checks++; if (ctl !== BRF) begin errors++; $display("FAIL br_over_lu got=%b exp=%b", ctl, BRF); end
    cyc;
    br_taken = 0; idex_mem_read = 0; #1;
    checks++; if (ctl !== RUN) begin errors++; $display("FAIL br_after got=%b exp=%b", ctl, RUN); end
    cyc;
    br_taken = 1; mem_read_req = 1; #1;
    checks++; if (ctl !== HOLD) begin errors++; $display("FAIL br_busy0 got=%b exp=%b", ctl, HOLD); end
    cyc;
    #1;
    checks++; if ({ctl, dmem_read} !== {HOLD, 1'b1}) begin errors++; $display("FAIL br_busy1 got=%b exp=%b", {ctl, dmem_read}, {HOLD, 1'b1}); end
    cyc;
    dmem_resp = 1; #1;
    checks++; if ({ctl, mdr_load} !== {BRF, 1'b1}) begin errors++; $display("FAIL br_done got=%b exp=%b", {ctl, mdr_load}, {BRF, 1'b1}); end
    cyc;
    idle_in; imem_resp = 1; #1;
    checks++; if (ctl !== RUN) begin errors++; $display("FAIL br_clear got=%b exp=%b", ctl, RUN); end
`ifdef PERF_CNT_EN
    checks++; if ({stall_if_cnt, stall_mem_cnt, stall_lu_cnt} !== {16'd6, 16'd10, 16'd2}) begin errors++; $display("FAIL cnt_tally got=%0d/%0d/%0d exp=6/10/2", stall_if_cnt, stall_mem_cnt, stall_lu_cnt); end
`endif
    cyc;
  endtask
  task test_reset_mid;
    idle_in; mem_write_req = 1; mem_indirect = 1; imem_resp = 1; #1;
    checks++; if (ctl !== HOLD) begin errors++; $display("FAIL rm_c0 got=%b exp=%b", ctl, HOLD); end
    cyc;
    imem_resp = 0; dmem_resp = 1; #1;
    checks++; if ({dmem_read, mdr_load} !== 2'b11) begin errors++; $display("FAIL rm_ind1 got=%b exp=11", {dmem_read, mdr_load}); end
    cyc;
    dmem_resp = 0; #1;
    checks++; if ({ind_phase2, dmem_write, dmem_read, imem_read} !== 4'b1100) begin errors++; $display("FAIL rm_ind2 got=%b exp=1100", {ind_phase2, dmem_write, dmem_read, imem_read}); end
    rst_n = 0; #1;
    checks++; if ({ind_phase2, dmem_write, dmem_read, imem_read} !== 4'b0000) begin errors++; $display("FAIL rm_async got=%b exp=0000", {ind_phase2, dmem_write, dmem_read, imem_read}); end
    checks++; if (ctl !== HOLD) begin errors++; $display("FAIL rm_ctl got=%b exp=%b", ctl, HOLD); end
`ifdef PERF_CNT_EN
    checks++; if ({stall_if_cnt, stall_mem_cnt, stall_lu_cnt} !== 48'd0) begin errors++; $display("FAIL rm_cnt got=%0d/%0d/%0d exp=0/0/0", stall_if_cnt, stall_mem_cnt, stall_lu_cnt); end
`endif
    idle_in;
    cyc;
    rst_n = 1; #1;
    checks++; if ({ind_phase2, dmem_write, dmem_read, imem_read} !== 4'b0001) begin errors++; $display("FAIL rm_rel got=%b exp=0001", {ind_phase2, dmem_write, dmem_read, imem_read}); end
    imem_resp = 1; #1;
    checks++; if (ctl !== RUN) begin errors++; $display("FAIL rm_run got=%b exp=%b", ctl, RUN); end
    cyc;
    mem_read_req = 1; #1;
    checks++; if ({ctl, dmem_read} !== {HOLD, 1'b0}) begin errors++; $display("FAIL rm_idle got=%b exp=%b", {ctl, dmem_read}, {HOLD, 1'b0}); end
    cyc;
    #1;
    checks++; if ({dmem_read, ind_phase2} !== 2'b10) begin errors++; $display("FAIL rm_acc got=%b exp=10", {dmem_read, ind_phase2}); end
    idle_in;
    cyc;
  endtask
  initial begin
    test_reset;
    test_fetch;
    test_ldr;
    test_back_to_back;
    test_ldi;
    test_load_use;
    test_branch;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
